// File: rtl/mdio_responder_if.sv
// Host-side MDIO pin bundle: MDC and the split MDIO data/enable pair.
// The host (station) drives mdc/mdio_i; the responder drives mdio_o/mdio_oe.
interface mdio_responder_if;
  logic mdc;
  logic mdio_i;
  logic mdio_o;
  logic mdio_oe;

  modport master (output mdc, output mdio_i, input mdio_o, input mdio_oe);
  modport slave  (input mdc, input mdio_i, output mdio_o, output mdio_oe);
endinterface

// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder presenting a virtual PHY built from fail-over status.
// Build option MDIO_PREAMBLE_SUPPRESS_EN: accept ST after a single preamble one, reg1 bit6 reads 1.
//
// state  | meaning
// S_PRE  | counting preamble ones, a 0 after enough ones is the ST start bit
// S_ST   | second ST bit, must be 1
// S_OP   | two opcode bits, 10 read / 01 write
// S_ADDR | PHYAD + REGAD, ten bits MSB first
// S_SKIP | frame for another PHY, let 18 bits pass undriven
// S_RTA  | read turnaround and 16 data bits driven by us
// S_WTA  | write turnaround and 16 data bits from the host
module mdio_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'd0,
  parameter logic [15:0] PHY_ID1      = 16'h0141,
  parameter logic [15:0] PHY_ID2      = 16'h0CC2,
  parameter int          PREAMBLE_MIN = 32
) (
  input  logic               clk,
  input  logic               rst,
  mdio_responder_if.slave    mdio,
  input  logic               link_up,
  input  logic [1:0]         speed,
  input  logic               full_duplex,
  input  logic               link_change,
  output logic               intr_n,
  output logic               soft_rst,
  output logic               reg_wr,
  output logic [4:0]         reg_wr_addr,
  output logic [15:0]        reg_wr_data
);

  localparam logic [5:0]  PRE_MIN   = 6'(PREAMBLE_MIN);
  localparam logic [14:0] REG0_RST  = 15'h1140;
  localparam logic [15:0] REG4_RST  = 16'h01E1;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam logic [5:0]  PRE_ACCEPT = 6'd1;
  localparam logic [15:0] REG1_BASE  = 16'h7949;
`else
  localparam logic [5:0]  PRE_ACCEPT = PRE_MIN;
  localparam logic [15:0] REG1_BASE  = 16'h7909;
`endif

  typedef enum logic [2:0] {
    S_PRE, S_ST, S_OP, S_ADDR, S_SKIP, S_RTA, S_WTA
  } state_t;

  state_t      state;
  logic [5:0]  ones_cnt;
  logic [4:0]  bit_cnt;
  logic        op_first;
  logic        is_read;
  logic [8:0]  addr_sr;
  logic [4:0]  regad_q;
  logic [15:0] wdata_sr;
  logic [15:0] snap;
  logic        mdio_o_r;
  logic        mdio_oe_r;

  logic mdc_s1, mdc_s2, mdc_s3;
  logic mdio_s1, mdio_s2;

  logic [14:0] reg0;
  logic [15:0] reg4;
  logic        int_en;
  logic        lc_latch;
  logic        link_ll;

  logic        rise;
  logic [9:0]  addr_full;
  logic        phy_match;
  logic        rd_snap;
  logic        wr_done;
  logic [15:0] wr_data_full;
  logic [15:0] rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      mdc_s1  <= 1'b0;
      mdc_s2  <= 1'b0;
      mdc_s3  <= 1'b0;
      mdio_s1 <= 1'b1;
      mdio_s2 <= 1'b1;
    end else begin
      mdc_s1  <= mdio.mdc;
      mdc_s2  <= mdc_s1;
      mdc_s3  <= mdc_s2;
      mdio_s1 <= mdio.mdio_i;
      mdio_s2 <= mdio_s1;
    end
  end

  assign rise         = mdc_s2 & ~mdc_s3;
  assign addr_full    = {addr_sr, mdio_s2};
  assign phy_match    = (addr_full[9:5] == PHY_ADDR);
  assign rd_snap      = rise && (state == S_ADDR) && (bit_cnt == 5'd0) && phy_match && is_read;
  assign wr_done      = rise && (state == S_WTA) && (bit_cnt == 5'd0);
  assign wr_data_full = {wdata_sr[14:0], mdio_s2};

  always_comb begin
    rd_data = 16'h0000;
    case (addr_full[4:0])
      5'd0:  rd_data = {1'b0, reg0};
      5'd1:  rd_data = REG1_BASE | {13'b0, link_ll, 2'b00};
      5'd2:  rd_data = PHY_ID1;
      5'd3:  rd_data = PHY_ID2;
      5'd4:  rd_data = reg4;
      5'd17: rd_data = {speed, full_duplex, 1'b0, link_up, link_up, 10'b0};
      5'd18: rd_data = {5'b0, int_en, 10'b0};
      5'd19: rd_data = {5'b0, lc_latch, 10'b0};
      default: rd_data = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_PRE;
      ones_cnt  <= 6'd0;
      bit_cnt   <= 5'd0;
      op_first  <= 1'b0;
      is_read   <= 1'b0;
      addr_sr   <= 9'd0;
      regad_q   <= 5'd0;
      wdata_sr  <= 16'h0000;
      snap      <= 16'h0000;
      mdio_o_r  <= 1'b1;
      mdio_oe_r <= 1'b0;
    end else if (rise) begin
      case (state)
        S_PRE: begin
          if (mdio_s2) begin
            if (ones_cnt != PRE_MIN) ones_cnt <= ones_cnt + 6'd1;
          end else begin
            if (ones_cnt >= PRE_ACCEPT) state <= S_ST;
            ones_cnt <= 6'd0;
          end
        end
        S_ST: begin
          if (mdio_s2) begin
            state   <= S_OP;
            bit_cnt <= 5'd1;
          end else begin
            state <= S_PRE;
          end
        end
        S_OP: begin
          if (bit_cnt != 5'd0) begin
            op_first <= mdio_s2;
            bit_cnt  <= 5'd0;
          end else begin
            bit_cnt <= 5'd9;
            case ({op_first, mdio_s2})
              2'b10: begin is_read <= 1'b1; state <= S_ADDR; end
              2'b01: begin is_read <= 1'b0; state <= S_ADDR; end
              default: state <= S_PRE;
            endcase
          end
        end
        S_ADDR: begin
          addr_sr <= addr_full[8:0];
          if (bit_cnt != 5'd0) begin
            bit_cnt <= bit_cnt - 5'd1;
          end else begin
            bit_cnt <= 5'd17;
            regad_q <= addr_full[4:0];
            if (!phy_match) begin
              state <= S_SKIP;
            end else if (is_read) begin
              snap  <= rd_data;
              state <= S_RTA;
            end else begin
              state <= S_WTA;
            end
          end
        end
        S_SKIP: begin
          if (bit_cnt != 5'd0) bit_cnt <= bit_cnt - 5'd1;
          else state <= S_PRE;
        end
        S_RTA: begin
          // bit_cnt 17 is the turnaround zero, 16..1 the data, 0 releases the line
          if (bit_cnt == 5'd17) begin
            mdio_oe_r <= 1'b1;
            mdio_o_r  <= 1'b0;
          end else if (bit_cnt == 5'd0) begin
            mdio_oe_r <= 1'b0;
            mdio_o_r  <= 1'b1;
            state     <= S_PRE;
          end else begin
            mdio_o_r <= snap[15];
            snap     <= {snap[14:0], 1'b0};
          end
          if (bit_cnt != 5'd0) bit_cnt <= bit_cnt - 5'd1;
        end
        S_WTA: begin
          wdata_sr <= wr_data_full;
          if (bit_cnt != 5'd0) bit_cnt <= bit_cnt - 5'd1;
          else state <= S_PRE;
        end
        default: state <= S_PRE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg0        <= REG0_RST;
      reg4        <= REG4_RST;
      int_en      <= 1'b0;
      lc_latch    <= 1'b0;
      link_ll     <= 1'b0;
      intr_n      <= 1'b1;
      soft_rst    <= 1'b0;
      reg_wr      <= 1'b0;
      reg_wr_addr <= 5'd0;
      reg_wr_data <= 16'h0000;
    end else begin
      soft_rst <= 1'b0;
      reg_wr   <= 1'b0;
      intr_n   <= ~(int_en & lc_latch);

      if (rd_snap && addr_full[4:0] == 5'd1) link_ll <= link_up;
      else if (!link_up)                     link_ll <= 1'b0;

      if (link_change)                            lc_latch <= 1'b1;
      else if (rd_snap && addr_full[4:0] == 5'd19) lc_latch <= 1'b0;

      if (wr_done) begin
        reg_wr      <= 1'b1;
        reg_wr_addr <= regad_q;
        reg_wr_data <= wr_data_full;
        case (regad_q)
          5'd0: begin
            if (wr_data_full[15]) begin
              soft_rst <= 1'b1;
              reg0     <= REG0_RST;
            end else begin
              reg0 <= wr_data_full[14:0];
            end
          end
          5'd4:  reg4   <= wr_data_full;
          5'd18: int_en <= wr_data_full[10];
          default: ;
        endcase
      end
    end
  end

  assign mdio.mdio_o  = mdio_o_r;
  assign mdio.mdio_oe = mdio_oe_r;

endmodule

// File: tb/tb_mdio_responder.sv
// Directed bench for mdio_responder: host-side MDIO frames with hand-computed register values.
module tb_mdio_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        link_up = 1'b1;
  logic [1:0]  speed = 2'b10;
  logic        full_duplex = 1'b1;
  logic        link_change = 1'b0;
  logic        intr_n;
  logic        soft_rst;
  logic        reg_wr;
  logic [4:0]  reg_wr_addr;
  logic [15:0] reg_wr_data;

  mdio_responder_if bus();

  mdio_responder dut (
    .clk         (clk),
    .rst         (rst),
    .mdio        (bus),
    .link_up     (link_up),
    .speed       (speed),
    .full_duplex (full_duplex),
    .link_change (link_change),
    .intr_n      (intr_n),
    .soft_rst    (soft_rst),
    .reg_wr      (reg_wr),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt = 0;
  int soft_cnt = 0;
  int oe_cycles = 0;
  logic s_o, s_oe;

  always @(posedge clk) begin
    if (reg_wr) wr_cnt <= wr_cnt + 1;
    if (soft_rst) soft_cnt <= soft_cnt + 1;
    if (bus.mdio_oe) oe_cycles <= oe_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One MDC period; the responder's line is sampled just before the rising edge.
  task automatic mdc_cycle(input logic b);
    bus.mdio_i = b;
    #70;
    s_o  = bus.mdio_o;
    s_oe = bus.mdio_oe;
    bus.mdc = 1'b1;
    #80;
    bus.mdc = 1'b0;
  endtask

  task automatic send_hdr(input int pre, input logic [1:0] op, input logic [4:0] phy, input logic [4:0] rega);
    logic [13:0] v;
    for (int i = 0; i < pre; i++) mdc_cycle(1'b1);
    v = {2'b01, op, phy, rega};
    for (int i = 13; i >= 0; i--) mdc_cycle(v[i]);
  endtask

  task automatic read_frame(input int pre, input logic [4:0] phy, input logic [4:0] rega,
                            output logic [15:0] data, output logic ta_ok,
                            output logic drv_ok, output logic end_ok);
    send_hdr(pre, 2'b10, phy, rega);
    mdc_cycle(1'b1);
    ta_ok = (s_oe === 1'b0);
    mdc_cycle(1'b1);
    ta_ok = ta_ok && (s_oe === 1'b1) && (s_o === 1'b0);
    drv_ok = 1'b1;
    for (int i = 15; i >= 0; i--) begin
      mdc_cycle(1'b1);
      data[i] = s_o;
      drv_ok = drv_ok && (s_oe === 1'b1);
    end
    mdc_cycle(1'b1);
    end_ok = (s_oe === 1'b0);
  endtask

  task automatic write_frame(input logic [4:0] phy, input logic [4:0] rega, input logic [15:0] d);
    send_hdr(32, 2'b01, phy, rega);
    mdc_cycle(1'b1);
    mdc_cycle(1'b0);
    for (int i = 15; i >= 0; i--) mdc_cycle(d[i]);
    bus.mdio_i = 1'b1;
    #100;
  endtask

  initial begin
    logic [15:0] rd;
    logic ta, dv, en;
    int oe0, wr0, sr0;
    logic [15:0] r1_lo, r1_hi;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    r1_lo = 16'h7949;
    r1_hi = 16'h794D;
`else
    r1_lo = 16'h7909;
    r1_hi = 16'h790D;
`endif
    bus.mdc = 1'b0;
    bus.mdio_i = 1'b1;
    #102;
    check("rst_mdio_oe", bus.mdio_oe, 1'b0);
    check("rst_mdio_o", bus.mdio_o, 1'b1);
    rst = 1'b0;
    #20;
    check("rst_intr_n", intr_n, 1'b1);
    check("rst_soft_rst", soft_rst, 1'b0);
    check("rst_reg_wr", reg_wr, 1'b0);
    check("rst_wr_addr", reg_wr_addr, 5'd0);
    check("rst_wr_data", reg_wr_data, 16'h0000);

    read_frame(32, 5'd0, 5'd2, rd, ta, dv, en);
    check("id1_ta", ta, 1'b1);
    check("id1_data", rd, 16'h0141);
    check("id1_drive", dv, 1'b1);
    check("id1_release", en, 1'b1);

    read_frame(32, 5'd0, 5'd3, rd, ta, dv, en);
    check("id2_data", rd, 16'h0CC2);

    read_frame(32, 5'd0, 5'd17, rd, ta, dv, en);
    check("reg17_ac00", rd, 16'hAC00);
    speed = 2'b01; full_duplex = 1'b0;
    read_frame(32, 5'd0, 5'd17, rd, ta, dv, en);
    check("reg17_100h", rd, 16'h4C00);
    speed = 2'b10; full_duplex = 1'b1;

    read_frame(32, 5'd0, 5'd1, rd, ta, dv, en);
    check("reg1_after_rst", rd, r1_lo);
    read_frame(32, 5'd0, 5'd1, rd, ta, dv, en);
    check("reg1_link_up", rd, r1_hi);
    link_up = 1'b0;
    #50;
    link_up = 1'b1;
    read_frame(32, 5'd0, 5'd1, rd, ta, dv, en);
    check("reg1_latched_low", rd, r1_lo);
    read_frame(32, 5'd0, 5'd1, rd, ta, dv, en);
    check("reg1_reloaded", rd, r1_hi);

    read_frame(32, 5'd0, 5'd0, rd, ta, dv, en);
    check("reg0_reset", rd, 16'h1140);
    read_frame(32, 5'd0, 5'd4, rd, ta, dv, en);
    check("reg4_reset", rd, 16'h01E1);

    wr0 = wr_cnt;
    write_frame(5'd0, 5'd4, 16'hABCD);
    check("wr4_pulse", wr_cnt - wr0, 1);
    check("wr4_addr", reg_wr_addr, 5'd4);
    check("wr4_data", reg_wr_data, 16'hABCD);
    read_frame(32, 5'd0, 5'd4, rd, ta, dv, en);
    check("reg4_rb", rd, 16'hABCD);

    write_frame(5'd0, 5'd0, 16'h0100);
    read_frame(32, 5'd0, 5'd0, rd, ta, dv, en);
    check("reg0_rb", rd, 16'h0100);
    sr0 = soft_cnt;
    write_frame(5'd0, 5'd0, 16'h8000);
    check("soft_rst_pulse", soft_cnt - sr0, 1);
    read_frame(32, 5'd0, 5'd0, rd, ta, dv, en);
    check("reg0_restored", rd, 16'h1140);

    wr0 = wr_cnt;
    write_frame(5'd0, 5'd7, 16'h1234);
    check("wr7_pulse", wr_cnt - wr0, 1);
    check("wr7_addr", reg_wr_addr, 5'd7);
    check("wr7_data", reg_wr_data, 16'h1234);
    read_frame(32, 5'd0, 5'd7, rd, ta, dv, en);
    check("reg7_zero", rd, 16'h0000);

    wr0 = wr_cnt;
    write_frame(5'd5, 5'd4, 16'h5555);
    check("wr_other_phy", wr_cnt - wr0, 0);

    write_frame(5'd0, 5'd18, 16'h0400);
    check("intr_before_lc", intr_n, 1'b1);
    link_change = 1'b1;
    #10;
    link_change = 1'b0;
    #50;
    check("intr_asserted", intr_n, 1'b0);
    read_frame(32, 5'd0, 5'd18, rd, ta, dv, en);
    check("reg18_rb", rd, 16'h0400);
    read_frame(32, 5'd0, 5'd19, rd, ta, dv, en);
    check("reg19_first", rd, 16'h0400);
    check("intr_cleared", intr_n, 1'b1);
    read_frame(32, 5'd0, 5'd19, rd, ta, dv, en);
    check("reg19_second", rd, 16'h0000);

    oe0 = oe_cycles;
    read_frame(32, 5'd3, 5'd2, rd, ta, dv, en);
    check("phy3_no_drive", oe_cycles - oe0, 0);
    read_frame(32, 5'd0, 5'd3, rd, ta, dv, en);
    check("after_phy3_data", rd, 16'h0CC2);
    check("after_phy3_ta", ta, 1'b1);

    oe0 = oe_cycles;
    read_frame(10, 5'd0, 5'd2, rd, ta, dv, en);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    check("short_pre_data", rd, 16'h0141);
    check("short_pre_ta", ta, 1'b1);
`else
    check("short_pre_ignored", oe_cycles - oe0, 0);
`endif
    read_frame(32, 5'd0, 5'd2, rd, ta, dv, en);
    check("after_short_data", rd, 16'h0141);

    send_hdr(32, 2'b10, 5'd0, 5'd2);
    repeat (12) mdc_cycle(1'b1);
    #30;
    check("oe_before_rst", bus.mdio_oe, 1'b1);
    rst = 1'b1;
    #10;
    check("oe_after_rst", bus.mdio_oe, 1'b0);
    check("o_after_rst", bus.mdio_o, 1'b1);
    rst = 1'b0;
    #20;
    read_frame(32, 5'd0, 5'd2, rd, ta, dv, en);
    check("post_rst_data", rd, 16'h0141);
    check("post_rst_release", en, 1'b1);
    read_frame(32, 5'd0, 5'd4, rd, ta, dv, en);
    check("post_rst_reg4", rd, 16'h01E1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
